// File: rtl/dplca_txop_table.sv
// Dynamic PLCA TXOP claim-table builder: records remote claims per TO and commits them at every PLCA cycle boundary.
// Define DPLCA_LOCAL_CONFLICT_EN to build the registered remote-claim-on-local-TO detector.
module dplca_txop_table #(
  parameter int unsigned AGE_CYCLES = 16
) (
  input  logic         clk,
  input  logic         plca_reset_n,
  input  logic         dplca_en,
  input  logic         dplca_aging,
  input  logic [7:0]   curID,
  input  logic [1:0]   rx_cmd,
  input  logic [1:0]   tx_cmd,
  input  logic         rx_activity,
  input  logic [7:0]   plca_node_count,
  input  logic [7:0]   local_nodeID,
  output logic [255:0] txop_claim_table,
  output logic         dplca_txop_table_upd,
  output logic         dplca_new_age,
  output logic [7:0]   dplca_txop_id,
  output logic [7:0]   dplca_txop_node_count,
  output logic         dplca_local_conflict
);

  localparam logic [1:0] CMD_BEACON = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_NONE   = 2'b10;
  localparam logic [7:0] AGE_LAST   = 8'(AGE_CYCLES - 1);

  typedef enum logic {
    S_IDLE_CYCLE = 1'b0,
    S_COMMIT     = 1'b1
  } state_t;

  state_t       r_state;
  state_t       w_state_nxt;

  logic [1:0]   r_rx_cmd_q;
  logic [1:0]   r_tx_cmd_q;
  logic [255:0] r_seen;
  logic [255:0] r_table;
  logic [7:0]   r_max_seen;
  logic [7:0]   r_txop_id;
  logic [7:0]   r_node_count;
  logic [7:0]   r_cycle_cnt;
  logic         r_new_age;

  logic         w_claim;
  logic         w_rx_bcn_edge;
  logic         w_tx_bcn_edge;
  logic         w_boundary;
  logic         w_commit;
  logic         w_age;
  logic [255:0] w_claim_vec;
  logic [255:0] w_seen_incl;
  logic [7:0]   w_max_incl;
  logic [7:0]   w_id_accum;

  // Claim and boundary detection; a claim on the boundary clock is folded into the commit.
  assign w_claim       = ((rx_cmd == CMD_COMMIT) && (r_rx_cmd_q != CMD_COMMIT)) || rx_activity;
  assign w_rx_bcn_edge = (rx_cmd == CMD_BEACON) && (r_rx_cmd_q != CMD_BEACON);
  assign w_tx_bcn_edge = (tx_cmd == CMD_BEACON) && (r_tx_cmd_q != CMD_BEACON);
  assign w_boundary    = w_rx_bcn_edge || w_tx_bcn_edge;
  assign w_commit      = w_boundary && (r_state == S_IDLE_CYCLE);
  assign w_age         = dplca_aging && (r_cycle_cnt == AGE_LAST);
  assign w_claim_vec   = w_claim ? (256'd1 << curID) : 256'd0;
  assign w_seen_incl   = r_seen | w_claim_vec;
  assign w_max_incl    = (w_claim && (curID > r_max_seen)) ? curID : r_max_seen;
  assign w_id_accum    = (w_max_incl > r_txop_id) ? w_max_incl : r_txop_id;

  // A boundary arriving while COMMIT is still active is merged into the previous one.
  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      r_state <= S_IDLE_CYCLE;
    end else if (!dplca_en) begin
      r_state <= S_IDLE_CYCLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: default assignment first so no path through the case can infer a latch.
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE_CYCLE: if (w_boundary) w_state_nxt = S_COMMIT;
      S_COMMIT:     w_state_nxt = S_IDLE_CYCLE;
      default:      w_state_nxt = S_IDLE_CYCLE;
    endcase
  end

  always_comb begin
    dplca_txop_table_upd = 1'b0;
    if (r_state == S_COMMIT) dplca_txop_table_upd = 1'b1;
  end

  // Command history clears to NONE so a BEACON already on the bus at release still forms a boundary.
  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      // NOTE: the 256-bit tables are plain flops, not RAM, so they take the reset like any other state.
      r_rx_cmd_q   <= CMD_NONE;
      r_tx_cmd_q   <= CMD_NONE;
      r_seen       <= '0;
      r_table      <= '0;
      r_max_seen   <= '0;
      r_txop_id    <= '0;
      r_node_count <= '0;
      r_cycle_cnt  <= '0;
      r_new_age    <= 1'b0;
    end else if (!dplca_en) begin
      r_rx_cmd_q   <= CMD_NONE;
      r_tx_cmd_q   <= CMD_NONE;
      r_seen       <= '0;
      r_table      <= '0;
      r_max_seen   <= '0;
      r_txop_id    <= '0;
      r_node_count <= '0;
      r_cycle_cnt  <= '0;
      r_new_age    <= 1'b0;
    end else begin
      r_rx_cmd_q <= rx_cmd;
      r_tx_cmd_q <= tx_cmd;
      if (w_commit) begin
        r_node_count <= plca_node_count;
        if (w_age) begin
          r_table     <= w_seen_incl;
          r_txop_id   <= w_max_incl;
          r_seen      <= '0;
          r_max_seen  <= '0;
          r_cycle_cnt <= '0;
          r_new_age   <= 1'b1;
        end else begin
          r_table    <= r_table | w_seen_incl;
          r_txop_id  <= w_id_accum;
          r_seen     <= w_seen_incl;
          r_max_seen <= w_max_incl;
          if (dplca_aging) r_cycle_cnt <= r_cycle_cnt + 8'd1;
          r_new_age  <= 1'b0;
        end
      end else begin
        r_seen     <= w_seen_incl;
        r_max_seen <= w_max_incl;
      end
    end
  end

  assign txop_claim_table      = r_table;
  assign dplca_txop_id         = r_txop_id;
  assign dplca_txop_node_count = r_node_count;
  assign dplca_new_age         = r_new_age;

`ifdef DPLCA_LOCAL_CONFLICT_EN
  logic r_conflict;

  always_ff @(posedge clk or negedge plca_reset_n) begin
    if (!plca_reset_n) begin
      r_conflict <= 1'b0;
    end else if (!dplca_en) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_claim && (curID == local_nodeID);
    end
  end

  assign dplca_local_conflict = r_conflict;
`else
  logic w_unused_local_id;

  assign w_unused_local_id    = ^local_nodeID;
  assign dplca_local_conflict = 1'b0;
`endif

endmodule

// File: tb/tb_dplca_txop_table.sv
// Self-checking bench for dplca_txop_table: directed scenarios plus randomized PLCA cycles against a set-based model.
module tb_dplca_txop_table;

  localparam int AGE = 4;
  localparam logic [1:0] BCN = 2'b00;
  localparam logic [1:0] CMT = 2'b01;
  localparam logic [1:0] NON = 2'b10;
`ifdef DPLCA_LOCAL_CONFLICT_EN
  localparam bit CONFLICT_ON = 1'b1;
`else
  localparam bit CONFLICT_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         plca_reset_n;
  logic         dplca_en;
  logic         dplca_aging;
  logic [7:0]   curID;
  logic [1:0]   rx_cmd;
  logic [1:0]   tx_cmd;
  logic         rx_activity;
  logic [7:0]   plca_node_count;
  logic [7:0]   local_nodeID;
  logic [255:0] txop_claim_table;
  logic         dplca_txop_table_upd;
  logic         dplca_new_age;
  logic [7:0]   dplca_txop_id;
  logic [7:0]   dplca_txop_node_count;
  logic         dplca_local_conflict;

  dplca_txop_table #(.AGE_CYCLES(AGE)) dut (
    .clk                   (clk),
    .plca_reset_n          (plca_reset_n),
    .dplca_en              (dplca_en),
    .dplca_aging           (dplca_aging),
    .curID                 (curID),
    .rx_cmd                (rx_cmd),
    .tx_cmd                (tx_cmd),
    .rx_activity           (rx_activity),
    .plca_node_count       (plca_node_count),
    .local_nodeID          (local_nodeID),
    .txop_claim_table      (txop_claim_table),
    .dplca_txop_table_upd  (dplca_txop_table_upd),
    .dplca_new_age         (dplca_new_age),
    .dplca_txop_id         (dplca_txop_id),
    .dplca_txop_node_count (dplca_txop_node_count),
    .dplca_local_conflict  (dplca_local_conflict)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: set of TOs claimed in the current window, committed table, window position.
  logic [255:0] m_seen;
  logic [255:0] m_tab;
  int           m_cnt;
  bit           m_new_age;
  logic [7:0]   m_nc;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] top_id(input logic [255:0] v);
    logic [7:0] r;
    r = 8'd0;
    for (int i = 0; i < 256; i++) if (v[i]) r = 8'(i);
    return r;
  endfunction

  task automatic model_clear();
    m_seen    = '0;
    m_tab     = '0;
    m_cnt     = 0;
    m_new_age = 1'b0;
    m_nc      = 8'd0;
  endtask

  task automatic model_boundary();
    if (dplca_aging && (m_cnt == AGE - 1)) begin
      m_tab     = m_seen;
      m_seen    = '0;
      m_cnt     = 0;
      m_new_age = 1'b1;
    end else begin
      m_tab     = m_tab | m_seen;
      if (dplca_aging) m_cnt++;
      m_new_age = 1'b0;
    end
    m_nc = plca_node_count;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit exp_upd, input bit exp_conf);
    check({tag, ".upd"},      dplca_txop_table_upd, exp_upd);
    check({tag, ".new_age"},  dplca_new_age, m_new_age);
    check({tag, ".table"},    txop_claim_table, m_tab);
    check({tag, ".id"},       dplca_txop_id, top_id(m_tab));
    check({tag, ".nc"},       dplca_txop_node_count, m_nc);
    check({tag, ".conflict"}, dplca_local_conflict, exp_conf);
  endtask

  task automatic claim(input int id, input bit use_act);
    curID = 8'(id);
    if (use_act) rx_activity = 1'b1;
    else rx_cmd = CMT;
    m_seen[id] = 1'b1;
    tick();
    check_all("claim", 1'b0, CONFLICT_ON && (id == int'(local_nodeID)));
    rx_activity = 1'b0;
    rx_cmd      = NON;
    tick();
    check_all("claim_gap", 1'b0, 1'b0);
  endtask

  task automatic boundary(input bit rx, input bit tx, input int hold, input int race_id);
    if (rx) rx_cmd = BCN;
    if (tx) tx_cmd = BCN;
    if (race_id >= 0) begin
      curID           = 8'(race_id);
      rx_activity     = 1'b1;
      m_seen[race_id] = 1'b1;
    end
    model_boundary();
    tick();
    check_all("commit", 1'b1, CONFLICT_ON && (race_id >= 0) && (race_id == int'(local_nodeID)));
    rx_activity = 1'b0;
    for (int i = 1; i < hold; i++) begin
      tick();
      check_all("beacon_hold", 1'b0, 1'b0);
    end
    rx_cmd = NON;
    tx_cmd = NON;
    tick();
    check_all("after_beacon", 1'b0, 1'b0);
  endtask

  initial begin
    plca_reset_n    = 1'b0;
    dplca_en        = 1'b1;
    dplca_aging     = 1'b0;
    curID           = 8'd0;
    rx_cmd          = NON;
    tx_cmd          = NON;
    rx_activity     = 1'b0;
    plca_node_count = 8'd0;
    local_nodeID    = 8'd4;
    model_clear();
    tick();
    tick();
    check_all("reset", 1'b0, 1'b0);
    plca_reset_n = 1'b1;
    tick();

    // Accumulate without aging: TO 2 then TO 5.
    plca_node_count = 8'd8;
    claim(2, 1'b0);
    boundary(1'b1, 1'b0, 1, -1);
    claim(5, 1'b0);
    boundary(1'b0, 1'b1, 1, -1);
    check("acc.table", txop_claim_table, 256'h24);
    check("acc.id", dplca_txop_id, 8'd5);
    check("acc.new_age", dplca_new_age, 1'b0);

    // Asynchronous reset mid-cycle after a claim on TO 3.
    claim(3, 1'b1);
    plca_reset_n = 1'b0;
    #2;
    model_clear();
    check_all("async_reset", 1'b0, 1'b0);
    tick();
    plca_reset_n = 1'b1;
    tick();
    boundary(1'b1, 1'b0, 1, -1);
    check("post_reset.table", txop_claim_table, 256'h0);

    // Synchronous clear through dplca_en.
    claim(6, 1'b0);
    boundary(1'b1, 1'b0, 1, -1);
    dplca_en = 1'b0;
    tick();
    model_clear();
    check_all("en_clear", 1'b0, 1'b0);
    dplca_en = 1'b1;
    tick();

    // Aging: TO 7 in window 1, TO 1 in window 2.
    dplca_aging = 1'b1;
    claim(7, 1'b0);
    for (int b = 1; b <= 4; b++) boundary(1'b1, 1'b0, 1, -1);
    check("age1.table", txop_claim_table, 256'h80);
    check("age1.new_age", dplca_new_age, 1'b1);
    claim(1, 1'b1);
    boundary(1'b1, 1'b0, 1, -1);
    check("age2.new_age_fall", dplca_new_age, 1'b0);
    for (int b = 6; b <= 8; b++) boundary(1'b1, 1'b0, 1, -1);
    check("age2.table", txop_claim_table, 256'h2);
    check("age2.id", dplca_txop_id, 8'd1);

    // Same-clock race on an age boundary, then a whole window with no claims.
    for (int b = 1; b <= 3; b++) boundary(1'b0, 1'b1, 1, -1);
    boundary(1'b1, 1'b0, 1, 9);
    check("race.table", txop_claim_table, 256'd1 << 9);
    for (int b = 1; b <= 4; b++) boundary(1'b1, 1'b0, 1, -1);
    check("race.not_carried", txop_claim_table, 256'h0);

    // Merged rx+tx BEACON held for three clocks.
    plca_node_count = 8'd12;
    boundary(1'b1, 1'b1, 3, -1);
    check("merged.nc", dplca_txop_node_count, 8'd12);

    // tx BEACON edge one clock after the rx edge is merged into one boundary.
    plca_node_count = 8'd13;
    rx_cmd = BCN;
    model_boundary();
    tick();
    check_all("spacing.first", 1'b1, 1'b0);
    tx_cmd = BCN;
    tick();
    check_all("spacing.merged", 1'b0, 1'b0);
    rx_cmd = NON;
    tx_cmd = NON;
    tick();
    check_all("spacing.idle", 1'b0, 1'b0);

    // Claim on the local TO.
    claim(4, 1'b0);
    boundary(1'b1, 1'b0, 1, -1);

    // Randomized PLCA cycles, including aging toggled mid-window.
    for (int it = 0; it < 48; it++) begin
      int n;
      int sel;
      plca_node_count = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) dplca_aging = ~dplca_aging;
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) claim($urandom_range(0, 255), 1'($urandom_range(0, 1)));
      sel = $urandom_range(1, 3);
      boundary(sel[0], sel[1], $urandom_range(1, 3),
               ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
